// File: rtl/ovl_window_arb_ctrl.sv
// Round-robin write-channel arbiter that frames each grant as a
// start/window/end transaction with a per-beat ack watchdog.
module ovl_window_arb_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     wr_ack,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     start_event,
  output logic                     window,
  output logic                     end_event,
  output logic                     wr_val,
  output logic                     wr_done,
  output logic                     err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER,
    DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [LEN_W-1:0]   pick_len;
  logic [LEN_W:0]     cnt;
  logic [WD_W-1:0]    wd;
  logic               abort;

  // Rotating priority search starting at rr_ptr
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  assign pick_len = req_len[pick*LEN_W +: LEN_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      win    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      wd     <= '0;
      abort  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            win   <= pick;
            cnt   <= {1'b0, pick_len} + 1'b1;
            wd    <= '0;
            abort <= 1'b0;
            state <= START;
          end
        end
        START: state <= XFER;
        XFER: begin
          if (wr_ack) begin
            cnt <= cnt - 1'b1;
            wd  <= '0;
            if (cnt == (LEN_W+1)'(1)) state <= DONE;
          end else if (wd == WD_W'(TIMEOUT-1)) begin
            abort <= 1'b1;
            state <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          if (win == IDX_W'(NUM_REQ-1)) rr_ptr <= '0;
          else rr_ptr <= win + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    if (state != IDLE) gnt[win] = 1'b1;
  end

  assign start_event = (state == START);
  assign window      = (state == XFER) || (state == DONE);
  assign end_event   = (state == DONE);
  assign wr_val      = (state == XFER);
  assign wr_done     = (state == DONE) && !abort;
  assign err         = (state == DONE) && abort;

endmodule

// File: tb/tb_ovl_window_arb_ctrl.sv
// Randomized transaction-level bench for ovl_window_arb_ctrl with
// a rotating-priority reference model and ack-stream outcome predictor.
module tb_ovl_window_arb_ctrl;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [15:0]   req_len = '0;
  logic          wr_ack = 1'b0;
  logic [N-1:0]  gnt;
  logic          start_event;
  logic          window;
  logic          end_event;
  logic          wr_val;
  logic          wr_done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  bit pat[$];

  ovl_window_arb_ctrl #(
    .NUM_REQ(N),
    .LEN_W(LW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_len(req_len),
    .wr_ack(wr_ack),
    .gnt(gnt),
    .start_event(start_event),
    .window(window),
    .end_event(end_event),
    .wr_val(wr_val),
    .wr_done(wr_done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, 32'({gnt, start_event, window, end_event,
                  wr_val, wr_done, err}), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req = 4'hF;
    repeat (n) begin
      step;
      idle_chk("reset_outputs");
    end
    rst = 1'b0;
    req = '0;
    m_ptr = 0;
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic txn(input logic [N-1:0] rq, input logic [15:0] lens,
                     input int pct);
    int win;
    int beats;
    int exp_x;
    int left;
    int run;
    bit ab;
    bit a[$];
    logic [N-1:0] exp_gnt;

    win = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (win < 0 && rq[j]) win = j;
    end
    beats = int'((lens >> (win * LW)) & 16'hF) + 1;
    exp_gnt = N'(1) << win;

    a = pat;
    while (a.size() < beats * TO + 1)
      a.push_back($urandom_range(99) < pct);
    left = beats;
    run = 0;
    ab = 1'b0;
    exp_x = 0;
    for (int k = 0; k < a.size(); k++) begin
      if (a[k]) begin
        left--;
        run = 0;
      end else begin
        run++;
      end
      if (left == 0 || run == TO) begin
        ab = (left != 0);
        exp_x = k + 1;
        break;
      end
    end

    idle_chk("idle_before_req");
    req = rq;
    req_len = lens;
    step;
    chk("start_event", 32'(start_event), 32'd1);
    chk("start_gnt", 32'(gnt), 32'(exp_gnt));
    chk("start_quiet", 32'({window, wr_val, end_event, wr_done, err}), 32'd0);
    req = N'($urandom);
    req_len = 16'($urandom);
    wr_ack = 1'($urandom);

    for (int k = 0; k < exp_x; k++) begin
      step;
      chk("xfer_flags", 32'({wr_val, window, start_event, end_event,
                             wr_done, err}), 32'b110000);
      chk("xfer_gnt", 32'(gnt), 32'(exp_gnt));
      wr_ack = a[k];
    end

    step;
    chk("done_flags", 32'({end_event, window, wr_val, start_event}),
        32'b1100);
    chk("done_wr_done", 32'(wr_done), 32'(!ab));
    chk("done_err", 32'(err), 32'(ab));
    chk("done_gnt", 32'(gnt), 32'(exp_gnt));
    req = '0;
    wr_ack = 1'($urandom);
    m_ptr = (win + 1) % N;
    pat.delete();
    step;
  endtask

  initial begin
    do_reset(5);

    txn(4'b0100, 16'h0300, 100);

    do_reset(1);
    repeat (5) txn(4'b1111, 16'h0000, 100);

    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    txn(4'b0010, 16'h0010, 100);

    txn(4'b0100, 16'h0200, 0);
    txn(4'b1111, 16'h0000, 100);

    idle_chk("idle_before_midreset");
    req = 4'b0100;
    req_len = 16'h0300;
    wr_ack = 1'b1;
    step;
    chk("mid_start", 32'(start_event), 32'd1);
    step;
    step;
    chk("mid_second_beat", 32'(wr_val), 32'd1);
    rst = 1'b1;
    step;
    idle_chk("mid_reset_outputs");
    rst = 1'b0;
    req = '0;
    m_ptr = 0;
    txn(4'b0010, 16'($urandom), 100);

    repeat (40) begin
      logic [N-1:0] r;
      r = N'($urandom_range(15, 1));
      txn(r, 16'($urandom), int'($urandom_range(100, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
